// File: rtl/dm_lsu_pkg.sv
// Shared encodings for the data-memory load/store unit: access sizes, FSM states
// and the alignment check used when DM_LSU_MISALIGN_TRAP_EN is defined.
package dm_lsu_pkg;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_RSV = 2'b11;

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  function automatic logic is_misaligned(logic [1:0] size, logic [1:0] addr_lo);
    return ((size == SZ_H) && addr_lo[0]) || ((size == SZ_W) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/dm_lsu_if.sv
// Core request/response handshake plus the single-port data-memory bus.
// master = core and memory side, slave = the LSU.
interface dm_lsu_if #(
  parameter int unsigned ADDR_W = 16
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              dm_enable;
  logic              dm_write;
  logic [ADDR_W-1:0] dm_address;
  logic [31:0]       dm_in;
  logic [31:0]       dm_out;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, dm_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, dm_enable, dm_write, dm_address, dm_in
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, dm_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, dm_enable, dm_write, dm_address, dm_in
  );

endinterface

// File: rtl/dm_lsu_align.sv
// Little-endian lane handling: extracts and extends load data, and merges sub-word
// store data into a previously read word.
module dm_lsu_align
  import dm_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        zext,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = rword[{offset, 3'b000} +: 8];
    half_sel  = offset[1] ? rword[31:16] : rword[15:0];
    load_data = rword;
    merged    = wdata;
    case (size)
      SZ_B: begin
        load_data = {{24{~zext & byte_sel[7]}}, byte_sel};
        merged    = rword;
        merged[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_H: begin
        load_data = {{16{~zext & half_sel[15]}}, half_sel};
        merged    = rword;
        merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data = rword;
        merged    = wdata;
      end
    endcase
  end

endmodule

// File: rtl/dm_lsu.sv
// Load/store unit for a single-port data memory; sub-word stores use read-modify-write.
// Define DM_LSU_MISALIGN_TRAP_EN to reject misaligned accesses instead of force-aligning.
module dm_lsu
  import dm_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input logic     clk,
  input logic     rst_n,
  dm_lsu_if.slave bus
);

  state_e            state_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;
  logic              dm_enable_q;
  logic              dm_write_q;
  logic [ADDR_W-1:0] dm_address_q;
  logic [31:0]       dm_in_q;

  logic              we_q;
  logic [1:0]        size_q;
  logic              zext_q;
  logic [1:0]        off_q;
  logic [31:0]       wdata_q;

  logic              accept;
  logic              bad_req;
  logic [1:0]        off_in;
  logic [31:0]       load_data;
  logic [31:0]       merged;

  logic unused_addr;
  assign unused_addr = ^bus.req_addr[31:ADDR_W+2];

  always_comb begin
    accept = bus.req_valid && req_ready_q;
    // Force-align the lane offset; only matters when misaligned accesses are not trapped.
    case (bus.req_size)
      SZ_H:    off_in = {bus.req_addr[1], 1'b0};
      SZ_W:    off_in = 2'b00;
      default: off_in = bus.req_addr[1:0];
    endcase
`ifdef DM_LSU_MISALIGN_TRAP_EN
    bad_req = (bus.req_size == SZ_RSV) || is_misaligned(bus.req_size, bus.req_addr[1:0]);
`else
    bad_req = (bus.req_size == SZ_RSV);
`endif
  end

  dm_lsu_align u_align (
    .size      (size_q),
    .zext      (zext_q),
    .offset    (off_q),
    .wdata     (wdata_q),
    .rword     (bus.dm_out),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      dm_enable_q  <= 1'b1;
      dm_write_q   <= 1'b1;
      dm_address_q <= '0;
      dm_in_q      <= '0;
      we_q         <= 1'b0;
      size_q       <= SZ_B;
      zext_q       <= 1'b0;
      off_q        <= 2'b00;
      wdata_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            req_ready_q  <= 1'b0;
            we_q         <= bus.req_we;
            size_q       <= bus.req_size;
            zext_q       <= bus.req_unsigned;
            off_q        <= off_in;
            wdata_q      <= bus.req_wdata;
            dm_address_q <= bus.req_addr[ADDR_W+1:2];
            if (bad_req) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else if (bus.req_we && (bus.req_size == SZ_W)) begin
              state_q     <= StWr;
              dm_enable_q <= 1'b0;
              dm_write_q  <= 1'b0;
              dm_in_q     <= bus.req_wdata;
            end else begin
              state_q     <= StRd;
              dm_enable_q <= 1'b0;
              dm_write_q  <= 1'b1;
            end
          end
        end
        StRd: begin
          if (we_q) begin
            state_q    <= StWr;
            dm_write_q <= 1'b0;
            dm_in_q    <= merged;
          end else begin
            state_q     <= StResp;
            dm_enable_q <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= load_data;
          end
        end
        StWr: begin
          state_q     <= StResp;
          dm_enable_q <= 1'b1;
          dm_write_q  <= 1'b1;
          dm_in_q     <= '0;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= '0;
        end
        StResp: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.dm_enable  = dm_enable_q;
  assign bus.dm_write   = dm_write_q;
  assign bus.dm_address = dm_address_q;
  assign bus.dm_in      = dm_in_q;

endmodule

// File: tb/tb_dm_lsu.sv
// Directed bench for dm_lsu: vector table of loads/stores against a word memory model,
// plus hand-written reset and wrap sequences.
module tb_dm_lsu;
  import dm_lsu_pkg::*;

  localparam int unsigned ADDR_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dm_lsu_if #(.ADDR_W(ADDR_W)) bus ();

  dm_lsu #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  int unsigned       n_rd = 0;
  int unsigned       n_wr = 0;
  int unsigned       n_rsp = 0;
  logic [ADDR_W-1:0] last_wr_addr = '0;

  assign bus.dm_out = mem[bus.dm_address];

  always @(posedge clk) begin
    if (!bus.dm_enable && bus.dm_write) n_rd <= n_rd + 1;
    if (!bus.dm_enable && !bus.dm_write) begin
      n_wr <= n_wr + 1;
      mem[bus.dm_address] <= bus.dm_in;
      last_wr_addr <= bus.dm_address;
    end
    if (bus.rsp_valid) n_rsp <= n_rsp + 1;
  end

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic run(input vec_t v, output logic [31:0] rdata, output logic err,
                     output int lat);
    int guard;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (!bus.req_ready) fail_now({v.name, "_ready"});
    bus.req_valid    = 1'b1;
    bus.req_we       = v.we;
    bus.req_size     = v.size;
    bus.req_unsigned = v.uns;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    tick();
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 10) begin
      tick();
      lat++;
    end
    if (!bus.rsp_valid) fail_now({v.name, "_rsp"});
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    tick();
  endtask

  vec_t vt[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int unsigned rd0, wr0, rsp0;
    vec_t        v;

    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = SZ_W;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;

    //            name      we    size    uns   addr            wdata          rdata        err  lat rd wr
    vt.push_back('{"sw100",  1'b1, SZ_W,   1'b0, 32'h0000_0100, 32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1});
    vt.push_back('{"lw100",  1'b0, SZ_W,   1'b0, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 0});
    vt.push_back('{"sw_rmw", 1'b1, SZ_W,   1'b0, 32'h0000_0100, 32'h11223344, 32'h0,        1'b0, 2, 0, 1});
    vt.push_back('{"sb102",  1'b1, SZ_B,   1'b0, 32'h0000_0102, 32'hFFFF_FFAA, 32'h0,       1'b0, 3, 1, 1});
    vt.push_back('{"lw_rmw", 1'b0, SZ_W,   1'b0, 32'h0000_0100, 32'h0,        32'h11AA3344, 1'b0, 2, 1, 0});
    vt.push_back('{"sw_ext", 1'b1, SZ_W,   1'b0, 32'h0000_0100, 32'h80FF7F01, 32'h0,        1'b0, 2, 0, 1});
    vt.push_back('{"lb101",  1'b0, SZ_B,   1'b0, 32'h0000_0101, 32'h0,        32'h0000007F, 1'b0, 2, 1, 0});
    vt.push_back('{"lbu103", 1'b0, SZ_B,   1'b1, 32'h0000_0103, 32'h0,        32'h00000080, 1'b0, 2, 1, 0});
    vt.push_back('{"lh102",  1'b0, SZ_H,   1'b0, 32'h0000_0102, 32'h0,        32'hFFFF80FF, 1'b0, 2, 1, 0});
    vt.push_back('{"lhu102", 1'b0, SZ_H,   1'b1, 32'h0000_0102, 32'h0,        32'h000080FF, 1'b0, 2, 1, 0});
    vt.push_back('{"lb103",  1'b0, SZ_B,   1'b0, 32'h0000_0103, 32'h0,        32'hFFFFFF80, 1'b0, 2, 1, 0});
`ifdef DM_LSU_MISALIGN_TRAP_EN
    vt.push_back('{"lw102",  1'b0, SZ_W,   1'b0, 32'h0000_0102, 32'h0,        32'h0,        1'b1, 1, 0, 0});
    vt.push_back('{"sh101",  1'b1, SZ_H,   1'b0, 32'h0000_0101, 32'h0000BEEF, 32'h0,        1'b1, 1, 0, 0});
    vt.push_back('{"lw_sh",  1'b0, SZ_W,   1'b0, 32'h0000_0100, 32'h0,        32'h80FF7F01, 1'b0, 2, 1, 0});
`else
    vt.push_back('{"lw102",  1'b0, SZ_W,   1'b0, 32'h0000_0102, 32'h0,        32'h80FF7F01, 1'b0, 2, 1, 0});
    vt.push_back('{"sh101",  1'b1, SZ_H,   1'b0, 32'h0000_0101, 32'h0000BEEF, 32'h0,        1'b0, 3, 1, 1});
    vt.push_back('{"lw_sh",  1'b0, SZ_W,   1'b0, 32'h0000_0100, 32'h0,        32'h80FFBEEF, 1'b0, 2, 1, 0});
`endif
    vt.push_back('{"rsv",    1'b1, SZ_RSV, 1'b0, 32'h0000_0100, 32'h12345678, 32'h0,        1'b1, 1, 0, 0});
    vt.push_back('{"rsv_ld", 1'b0, SZ_RSV, 1'b0, 32'h0000_0100, 32'h0,        32'h0,        1'b1, 1, 0, 0});

    // Reset values while rst_n is held low.
    tick();
    tick();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_dm_enable", 32'(bus.dm_enable), 32'd1);
    chk("rst_dm_write", 32'(bus.dm_write), 32'd1);
    chk("rst_dm_address", 32'(bus.dm_address), 32'd0);
    chk("rst_dm_in", bus.dm_in, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);

    foreach (vt[i]) begin
      v   = vt[i];
      rd0 = n_rd;
      wr0 = n_wr;
      run(v, rdata, err, lat);
      chk({v.name, "_rdata"}, rdata, v.rdata);
      chk({v.name, "_err"}, 32'(err), 32'(v.err));
      chk({v.name, "_lat"}, 32'(lat), 32'(v.lat));
      chk({v.name, "_nrd"}, n_rd - rd0, 32'(v.nrd));
      chk({v.name, "_nwr"}, n_wr - wr0, 32'(v.nwr));
      chk({v.name, "_pulse"}, 32'(bus.rsp_valid), 32'd0);
      chk({v.name, "_idle_en"}, 32'(bus.dm_enable), 32'd1);
      chk({v.name, "_idle_din"}, bus.dm_in, 32'd0);
      if (i == 0) chk("mem40_after_sw", mem[16'h0040], 32'hDEADBEEF);
    end

    // Wrap: byte address 0x0004_0000 maps to word 0.
    v = '{"wrap", 1'b1, SZ_W, 1'b0, 32'h0004_0000, 32'h5A5A1234, 32'h0, 1'b0, 2, 0, 1};
    run(v, rdata, err, lat);
    chk("wrap_addr", 32'(last_wr_addr), 32'd0);
    chk("wrap_mem0", mem[16'h0000], 32'h5A5A1234);

    // Reset in the RD cycle of a byte store aborts the write.
    v = '{"pre_rst", 1'b1, SZ_W, 1'b0, 32'h0000_0100, 32'h11223344, 32'h0, 1'b0, 2, 0, 1};
    run(v, rdata, err, lat);
    wr0  = n_wr;
    rsp0 = n_rsp;
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b1;
    bus.req_size     = SZ_B;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0000_0101;
    bus.req_wdata    = 32'h0000_0055;
    tick();
    bus.req_valid = 1'b0;
    chk("rmw_rd_enable", 32'(bus.dm_enable), 32'd0);
    chk("rmw_rd_write", 32'(bus.dm_write), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rmw_rst_enable", 32'(bus.dm_enable), 32'd1);
    chk("rmw_rst_write", 32'(bus.dm_write), 32'd1);
    chk("rmw_rst_ready", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("rmw_rel_ready", 32'(bus.req_ready), 32'd1);
    chk("rmw_no_write", n_wr - wr0, 32'd0);
    chk("rmw_no_rsp", n_rsp - rsp0, 32'd0);
    chk("rmw_mem40", mem[16'h0040], 32'h11223344);
    v = '{"post_rmw", 1'b0, SZ_W, 1'b0, 32'h0000_0100, 32'h0, 32'h11223344, 1'b0, 2, 1, 0};
    run(v, rdata, err, lat);
    chk("post_rmw_rdata", rdata, v.rdata);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
